// File: rtl/debounced_edge_detector_if.sv
// Signal bundle between the footswitch/control-line edge detector and its consumer.
// master drives raw inputs, mode and clears; slave returns levels, pulses and flags.
interface debounced_edge_detector_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   din;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   lvl;
    logic [N_CH-1:0]   e;
    logic [N_CH-1:0]   flag;
    logic [N_CH-1:0]   hold;

    modport master (output din, mode, clr, input lvl, e, flag, hold);
    modport slave  (input din, mode, clr, output lvl, e, flag, hold);
endinterface

// File: rtl/debounced_edge_detector.sv
// Multi-channel synchronise/debounce/edge-pulse block with sticky per-channel event flags.
// Optional long-press detection is compiled in when HOLD_DETECT_EN is defined.
module debounced_edge_detector #(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 16,
    parameter logic RST_LVL     = 1'b0,
    parameter int   HOLD_CYCLES = 48000
) (
    input  logic                    clk,
    input  logic                    nrst,
    debounced_edge_detector_if.slave bus
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_CH-1:0][CNT_W-1:0]       dbCnt_q, dbCnt_d;
    logic [N_CH-1:0]                  lvl_q, lvl_d;
    logic [N_CH-1:0]                  e_q, e_d;
    logic [N_CH-1:0]                  flag_q, flag_d;

    // The edge pulse is decided at the same edge that commits the new level, so e and lvl move together.
    always_comb begin
        sync_d  = sync_q;
        dbCnt_d = dbCnt_q;
        lvl_d   = lvl_q;
        e_d     = '0;
        for (int i = 0; i < N_CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.din[i]};
            if (sync_q[i][SYNC_STAGES-1] == lvl_q[i]) begin
                dbCnt_d[i] = '0;
            end else if (dbCnt_q[i] == CNT_LAST) begin
                dbCnt_d[i] = '0;
                lvl_d[i]   = sync_q[i][SYNC_STAGES-1];
                e_d[i]     = sync_q[i][SYNC_STAGES-1] ? bus.mode[2*i] : bus.mode[2*i+1];
            end else begin
                dbCnt_d[i] = dbCnt_q[i] + 1'b1;
            end
        end
        flag_d = (flag_q & ~bus.clr) | e_d;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_q  <= {(N_CH*SYNC_STAGES){RST_LVL}};
            dbCnt_q <= '0;
            lvl_q   <= {N_CH{RST_LVL}};
            e_q     <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            dbCnt_q <= dbCnt_d;
            lvl_q   <= lvl_d;
            e_q     <= e_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.lvl  = lvl_q;
    assign bus.e    = e_q;
    assign bus.flag = flag_q;

`ifdef HOLD_DETECT_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_CYCLES - 1);

    logic [N_CH-1:0][HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic [N_CH-1:0]             hold_q, hold_d;

    // Saturating at HOLD_CYCLES means the fire value is passed exactly once per press.
    always_comb begin
        holdCnt_d = holdCnt_q;
        hold_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!lvl_q[i]) begin
                holdCnt_d[i] = '0;
            end else begin
                if (holdCnt_q[i] == HOLD_FIRE) begin
                    hold_d[i] = 1'b1;
                end
                if (holdCnt_q[i] != HOLD_MAX) begin
                    holdCnt_d[i] = holdCnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            holdCnt_q <= '0;
            hold_q    <= '0;
        end else begin
            holdCnt_q <= holdCnt_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.hold = hold_q;
`else
    localparam int unusedHoldCycles = HOLD_CYCLES;

    assign bus.hold = '0;
`endif
endmodule

// File: tb/tb_debounced_edge_detector.sv
// Scoreboard bench: stimulus queues expected edge/hold pulses, a negedge monitor matches every pulse.
// A second instance with RST_LVL=1 and inputs held high must never pulse.
module tb_debounced_edge_detector;
    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int HOLD_CYCLES = 10;
    localparam int LAT         = SYNC_STAGES + DB_CYCLES;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int   ch;
        bit   isHold;
        logic val;
        int   cycle;
    } exp_t;

    exp_t sb[$];

    debounced_edge_detector_if #(.N_CH(N_CH)) bus0 ();
    debounced_edge_detector_if #(.N_CH(N_CH)) bus1 ();

    debounced_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES),
        .RST_LVL(1'b0), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut0 (.clk(clk), .nrst(nrst), .bus(bus0.slave));

    debounced_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES),
        .RST_LVL(1'b1), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut1 (.clk(clk), .nrst(nrst), .bus(bus1.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] din, input logic [2*N_CH-1:0] mode,
                                 input logic [N_CH-1:0] clr);
        bus0.din  = din;
        bus0.mode = mode;
        bus0.clr  = clr;
    endtask

    task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                               input logic [N_CH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
        end
    endtask

    task automatic expectEvent(input int ch, input bit isHold, input logic val, input int cycle);
        exp_t x;
        x.ch = ch; x.isHold = isHold; x.val = val; x.cycle = cycle;
        sb.push_back(x);
    endtask

    task automatic matchEvent(input int ch, input bit isHold, input logic val);
        int idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].ch == ch && sb[k].isHold == isHold) begin
                idx = k;
                break;
            end
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("[TB] FAIL %s ch%0d: unexpected pulse at cycle %0d, want none",
                     isHold ? "hold_pulse" : "edge_pulse", ch, cyc);
        end else begin
            if (sb[idx].cycle != cyc || sb[idx].val !== val) begin
                bad++;
                $display("[TB] FAIL %s ch%0d: got cycle %0d lvl %b, want cycle %0d lvl %b",
                         isHold ? "hold_pulse" : "edge_pulse", ch, cyc, val,
                         sb[idx].cycle, sb[idx].val);
            end
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (bus0.e[i] === 1'b1)    matchEvent(i, 1'b0, bus0.lvl[i]);
            if (bus0.hold[i] === 1'b1) matchEvent(i, 1'b1, 1'b1);
            if (bus1.e[i] === 1'b1) begin
                total++;
                bad++;
                $display("[TB] FAIL rstlvl1_pulse ch%0d at cycle %0d: got e=1, want 0", i, cyc);
            end
        end
    end

    task automatic expectHold(input int ch, input int cycle);
`ifdef HOLD_DETECT_EN
        expectEvent(ch, 1'b1, 1'b1, cycle);
`else
        if (ch < 0 || cycle < 0) $display("[TB] bad hold request");
`endif
    endtask

    initial begin
        int c;
        applyStimulus('0, '0, '0);
        bus1.din  = '1;
        bus1.mode = '1;
        bus1.clr  = '0;
        nrst = 1'b0;
        waitNeg(3);
        checkOutput("reset_lvl", bus0.lvl, 4'b0000);
        checkOutput("reset_e", bus0.e, 4'b0000);
        checkOutput("reset_flag", bus0.flag, 4'b0000);
        checkOutput("reset_hold", bus0.hold, 4'b0000);
        checkOutput("rstlvl1_lvl", bus1.lvl, 4'b1111);
        nrst = 1'b1;
        waitNeg(10);
        checkOutput("rstlvl1_lvl_after", bus1.lvl, 4'b1111);
        checkOutput("rstlvl1_e_after", bus1.e, 4'b0000);

        $display("[TB] clean rising edge on ch0");
        applyStimulus(4'b0001, 8'h01, '0);
        c = cyc;
        expectEvent(0, 1'b0, 1'b1, c + LAT);
        waitNeg(LAT - 1);
        checkOutput("rise_lvl_early", bus0.lvl, 4'b0000);
        waitNeg(1);
        checkOutput("rise_lvl", bus0.lvl, 4'b0001);
        checkOutput("rise_flag", bus0.flag, 4'b0001);
        waitNeg(1);
        checkOutput("rise_e_one_cycle", bus0.e, 4'b0000);
        applyStimulus(4'b0000, 8'h01, '0);
        waitNeg(LAT + 2);
        checkOutput("fall_lvl", bus0.lvl, 4'b0000);
        checkOutput("fall_flag_kept", bus0.flag, 4'b0001);

        $display("[TB] flag set/clear race on ch0");
        applyStimulus(4'b0000, 8'h03, 4'b0001);
        waitNeg(1);
        applyStimulus(4'b0000, 8'h03, '0);
        checkOutput("clr_flag", bus0.flag, 4'b0000);
        applyStimulus(4'b0001, 8'h03, '0);
        c = cyc;
        expectEvent(0, 1'b0, 1'b1, c + LAT);
        waitNeg(LAT - 1);
        applyStimulus(4'b0001, 8'h03, 4'b0001);
        waitNeg(1);
        applyStimulus(4'b0001, 8'h03, '0);
        checkOutput("race_set_wins", bus0.flag, 4'b0001);
        applyStimulus(4'b0001, 8'h03, 4'b0001);
        waitNeg(1);
        applyStimulus(4'b0001, 8'h03, '0);
        checkOutput("clr_alone", bus0.flag, 4'b0000);
        applyStimulus(4'b0000, 8'h03, '0);
        expectEvent(0, 1'b0, 1'b0, cyc + LAT);
        waitNeg(LAT + 2);
        checkOutput("both_fall_flag", bus0.flag, 4'b0001);
        applyStimulus(4'b0000, 8'h0C, 4'b1111);
        waitNeg(1);

        $display("[TB] glitch rejection on ch1");
        applyStimulus(4'b0010, 8'h0C, '0);
        waitNeg(DB_CYCLES - 1);
        applyStimulus(4'b0000, 8'h0C, '0);
        waitNeg(10);
        checkOutput("glitch_lvl", bus0.lvl, 4'b0000);
        checkOutput("glitch_flag", bus0.flag, 4'b0000);
        applyStimulus(4'b0010, 8'h0C, '0);
        c = cyc;
        expectEvent(1, 1'b0, 1'b1, c + LAT);
        waitNeg(DB_CYCLES);
        applyStimulus(4'b0000, 8'h0C, '0);
        expectEvent(1, 1'b0, 1'b0, c + DB_CYCLES + LAT);
        waitNeg(10);
        checkOutput("min_pulse_lvl", bus0.lvl, 4'b0000);
        checkOutput("min_pulse_flag", bus0.flag, 4'b0010);
        applyStimulus(4'b0000, 8'h30, 4'b1111);
        waitNeg(1);

        $display("[TB] both-edge mode on ch2");
        applyStimulus(4'b0100, 8'h30, '0);
        c = cyc;
        expectEvent(2, 1'b0, 1'b1, c + LAT);
        expectHold(2, c + LAT + HOLD_CYCLES);
        waitNeg(10);
        checkOutput("both_lvl_high", bus0.lvl, 4'b0100);
        waitNeg(10);
        applyStimulus(4'b0000, 8'h30, '0);
        expectEvent(2, 1'b0, 1'b0, cyc + LAT);
        waitNeg(8);
        checkOutput("both_lvl_low", bus0.lvl, 4'b0000);
        checkOutput("both_flag", bus0.flag, 4'b0100);
        applyStimulus(4'b0000, 8'h00, 4'b1111);
        waitNeg(1);

        $display("[TB] mode off on ch3");
        applyStimulus(4'b1000, 8'h00, '0);
        waitNeg(8);
        checkOutput("off_lvl", bus0.lvl, 4'b1000);
        checkOutput("off_flag", bus0.flag, 4'b0000);
        applyStimulus(4'b0000, 8'h00, '0);
        waitNeg(8);
        checkOutput("off_lvl_low", bus0.lvl, 4'b0000);

        $display("[TB] all channels at once, with long press");
        applyStimulus(4'b1111, 8'hFF, '0);
        c = cyc;
        for (int i = 0; i < N_CH; i++) begin
            expectEvent(i, 1'b0, 1'b1, c + LAT);
            expectHold(i, c + LAT + HOLD_CYCLES);
        end
        waitNeg(LAT);
        checkOutput("all_lvl", bus0.lvl, 4'b1111);
        checkOutput("all_flag", bus0.flag, 4'b1111);
        waitNeg(30);
        applyStimulus(4'b0000, 8'hFF, '0);
        for (int i = 0; i < N_CH; i++) expectEvent(i, 1'b0, 1'b0, cyc + LAT);
        waitNeg(8);
        checkOutput("all_lvl_low", bus0.lvl, 4'b0000);
        applyStimulus(4'b1000, 8'hFF, '0);
        c = cyc;
        expectEvent(3, 1'b0, 1'b1, c + LAT);
        expectHold(3, c + LAT + HOLD_CYCLES);
        waitNeg(25);
        applyStimulus(4'b0000, 8'hFF, '0);
        expectEvent(3, 1'b0, 1'b0, cyc + LAT);
        waitNeg(8);
        applyStimulus(4'b0000, 8'h01, 4'b1111);
        waitNeg(1);
        applyStimulus(4'b0000, 8'h01, '0);
        checkOutput("all_flag_cleared", bus0.flag, 4'b0000);

        $display("[TB] reset during debounce on ch0");
        applyStimulus(4'b0001, 8'h01, '0);
        waitNeg(3);
        nrst = 1'b0;
        waitNeg(1);
        checkOutput("rst_mid_lvl", bus0.lvl, 4'b0000);
        checkOutput("rst_mid_e", bus0.e, 4'b0000);
        checkOutput("rstlvl1_mid_lvl", bus1.lvl, 4'b1111);
        nrst = 1'b1;
        c = cyc;
        expectEvent(0, 1'b0, 1'b1, c + LAT);
        waitNeg(LAT - 1);
        checkOutput("rst_mid_lvl_early", bus0.lvl, 4'b0000);
        waitNeg(1);
        checkOutput("rst_mid_lvl_late", bus0.lvl, 4'b0001);
        waitNeg(2);
        applyStimulus(4'b0000, 8'h01, '0);
        waitNeg(LAT + 4);
        checkOutput("final_lvl", bus0.lvl, 4'b0000);
        checkOutput("rstlvl1_final_lvl", bus1.lvl, 4'b1111);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drained: got %0d pending pulses, want 0", sb.size());
            foreach (sb[k])
                $display("[TB] missing pulse ch%0d hold=%0d lvl=%b at cycle %0d",
                         sb[k].ch, sb[k].isHold, sb[k].val, sb[k].cycle);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
